// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared N:1 data mux. Each grant lasts up to
// BURST accepted beats, then the pointer rotates past the granted requester.
module rr_mux_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_sel,
  output logic                 busy
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          hit;
  logic [SW-1:0] pick;
  logic [SW-1:0] scan_idx;
  logic          sel_valid;
  logic [W-1:0]  slice [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*W +: W];
    end
  endgenerate

  // First valid requester at or after ptr; N is a power of two so the SW-bit add wraps.
  always_comb begin
    hit      = 1'b0;
    pick     = ptr_q;
    scan_idx = ptr_q;
    for (int k = 0; k < N; k++) begin
      scan_idx = ptr_q + SW'(k);
      if (!hit && req_valid[scan_idx]) begin
        pick = scan_idx;
        hit  = 1'b1;
      end
    end
  end

  assign sel_valid = req_valid[gnt_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!sel_valid) begin
          state_d = S_IDLE;
          ptr_d   = gnt_q + SW'(1);
        end else if (out_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(BURST)) begin
            state_d = S_IDLE;
            ptr_d   = gnt_q + SW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the registers, so reset clears them without a clock.
  always_comb begin
    busy      = (state_q == S_GRANT);
    out_sel   = gnt_q;
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (busy) begin
      out_valid        = sel_valid;
      out_data         = slice[gnt_q];
      req_ready[gnt_q] = out_ready;
    end
  end

endmodule
